// File: rtl/stream_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the block-RAM stream FIFO.
package stream_fifo_pkg;

  localparam int DEFAULT_WIDTH = 72;
  localparam int DEFAULT_DEPTH = 512;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Power-of-two depth keeps pointer wrap free; thresholds must be ordered.
  function automatic bit params_legal(input int depth, input int af, input int ae);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple-dual-port RAM with one write port and a registered (1-cycle) read port.
module sdp_bram #(
  parameter int WIDTH  = 72,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO: block RAM body plus a 2-entry prefetch stage (head + skid)
// that hides the RAM read latency and keeps ms_data stable while ms_valid && !ms_ready.
module bram_stream_fifo import stream_fifo_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 8,
  parameter int AE_THRESH = 8,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [WIDTH-1:0]  ss_data,
  input  logic              ss_valid,
  output logic              ss_ready,
  output logic [WIDTH-1:0]  ms_data,
  output logic              ms_valid,
  input  logic              ms_ready,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              almost_empty
);

  if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("bram_stream_fifo: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W + 1)'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_count, ram_count_next, level_next;
  logic              head_valid, skid_valid, inflight;
  logic [WIDTH-1:0]  head_data, skid_data, rdata;
  logic              push, pop, re;
  logic              head_keep, skid_keep;
  logic [1:0]        stage_after;
  logic              head_v_n, skid_v_n;
  logic [WIDTH-1:0]  head_d_n, skid_d_n;

  // Handshake: a beat transfers on a cycle where valid && ready at the rising edge;
  // ss_ready depends only on registered level and flush, ms_valid/ms_data only on registers.
  assign ss_ready = (level != DEPTH_L) && !flush;
  assign push     = ss_valid && ss_ready;
  assign ms_valid = head_valid;
  assign ms_data  = head_data;
  assign pop      = head_valid && ms_ready;

  always_comb begin
    head_keep   = pop ? skid_valid : head_valid;
    skid_keep   = skid_valid && !pop;
    stage_after = {1'b0, head_keep} + {1'b0, skid_keep} + {1'b0, inflight};
    // ram_count excludes this cycle's push, so a read never hits the word being written.
    re = (ram_count != '0) && (stage_after < 2'd2) && !flush;

    ram_count_next = ram_count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, re};
    level_next     = level + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

    head_v_n = head_keep;
    head_d_n = pop ? skid_data : head_data;
    skid_v_n = skid_keep;
    skid_d_n = skid_data;
    if (inflight) begin
      if (!head_keep) begin
        head_v_n = 1'b1;
        head_d_n = rdata;
      end else begin
        skid_v_n = 1'b1;
        skid_d_n = rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_count    <= '0;
      level        <= '0;
      head_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      inflight     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (re)   rd_ptr <= rd_ptr + 1'b1;
      ram_count    <= ram_count_next;
      level        <= level_next;
      inflight     <= re;
      head_valid   <= head_v_n;
      skid_valid   <= skid_v_n;
      head_data    <= head_d_n;
      skid_data    <= skid_d_n;
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (level <= DEPTH_L);
      assert (!(pop && level == '0));
    end
  end

  sdp_bram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(ss_data),
    .re   (re),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Scoreboard bench for bram_stream_fifo at DEPTH=8 so fill, wrap and flag edges are reachable.
module tb_bram_stream_fifo;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk, resetn, flush;
  logic [W-1:0]  ss_data, ms_data;
  logic          ss_valid, ss_ready, ms_valid, ms_ready;
  logic [3:0]    level;
  logic          almost_full, almost_empty;

  int            n_tests, n_fail, n_push, n_pop;
  logic [W-1:0]  exp_q[$];
  logic          mon_en, hold_prev;
  logic [W-1:0]  data_prev;

  bram_stream_fifo #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ss_data(ss_data), .ss_valid(ss_valid), .ss_ready(ss_ready),
    .ms_data(ms_data), .ms_valid(ms_valid), .ms_ready(ms_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    logic acc;
    acc = 1'b0;
    ss_valid = 1'b1;
    ss_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = ss_ready;
      step();
      if (acc) break;
    end
    ss_valid = 1'b0;
    if (!acc) check("push_timeout", 1, 0);
  endtask

  task automatic drain(input int cycles);
    ms_ready = 1'b1;
    repeat (cycles) step();
    ms_ready = 1'b0;
    check("drain_level", level, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  // scoreboard monitor: transfers are decided by signals stable at the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        check("hold_valid", ms_valid, 1);
        check("hold_data", ms_data, data_prev);
      end
      if (ms_valid === 1'b1 && ms_ready) begin
        n_pop++;
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_data", ms_data, exp_q.pop_front());
      end
      if (ss_valid && ss_ready === 1'b1) begin
        exp_q.push_back(ss_data);
        n_push++;
      end
      hold_prev = (ms_valid === 1'b1) && !ms_ready && resetn && !flush;
      data_prev = ms_data;
      if (flush || !resetn) exp_q.delete();
    end
  end

  initial begin
    int p0, cyc;
    n_tests = 0; n_fail = 0; n_push = 0; n_pop = 0;
    mon_en = 1'b0; hold_prev = 1'b0; data_prev = '0;
    resetn = 1'b0; flush = 1'b0; ss_valid = 1'b0; ss_data = '0; ms_ready = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    mon_en = 1'b1;
    check("rst_level", level, 0);
    check("rst_ms_valid", ms_valid, 0);
    check("rst_ss_ready", ss_ready, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);

    // 1: single word latency and hold
    push_word(16'h00A5);
    check("t1_valid_t0", ms_valid, 0);
    step();
    check("t1_valid_t1", ms_valid, 0);
    step();
    check("t1_valid_t2", ms_valid, 1);
    check("t1_data", ms_data, 16'h00A5);
    check("t1_level", level, 1);
    check("t1_ae", almost_empty, 1);
    repeat (10) step();
    check("t1_data_held", ms_data, 16'h00A5);
    drain(3);

    // 2: fill to exact full, reject extra word, drain in order
    for (int i = 0; i < D; i++) begin
      push_word(W'(i));
      check("t2_level", level, i + 1);
      check("t2_af", almost_full, (i + 1) >= AF);
      check("t2_ae", almost_empty, (i + 1) <= AE);
    end
    check("t2_ss_ready_full", ss_ready, 0);
    ss_valid = 1'b1;
    ss_data  = 16'h0009;
    repeat (3) step();
    ss_valid = 1'b0;
    check("t2_level_full", level, D);
    drain(12);

    // 3: continuous streaming at one word per cycle
    p0 = n_pop;
    ms_ready = 1'b1;
    ss_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ss_data = W'(100 + i);
      @(negedge clk);
      if (!ss_ready) check("t3_ss_ready", ss_ready, 1);
      step();
      if (level != ((i < 3) ? i + 1 : 3)) check("t3_level", level, (i < 3) ? i + 1 : 3);
      if (ms_valid != (i >= 2)) check("t3_ms_valid", ms_valid, i >= 2);
    end
    ss_valid = 1'b0;
    repeat (5) step();
    check("t3_pops", n_pop - p0, 1000);
    check("t3_level_end", level, 0);

    // 4: random valid/ready
    p0  = n_push;
    cyc = 0;
    while ((n_push - p0) < 10000 && cyc < 60000) begin
      ss_valid = 1'($urandom_range(0, 1));
      ss_data  = W'($urandom_range(0, 16'hFFFF));
      ms_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    ss_valid = 1'b0;
    check("t4_pushes", (n_push - p0) >= 10000, 1);
    drain(20);

    // 5: flush with a word presented in the same cycle
    for (int i = 0; i < 5; i++) push_word(W'(16'h50 + i));
    repeat (3) step();
    flush = 1'b1;
    ss_valid = 1'b1;
    ss_data = 16'h0077;
    step();
    flush = 1'b0;
    ss_valid = 1'b0;
    check("t5_level", level, 0);
    check("t5_ms_valid", ms_valid, 0);
    check("t5_ae", almost_empty, 1);
    check("t5_af", almost_full, 0);
    push_word(16'h003C);
    step();
    step();
    check("t5_first_valid", ms_valid, 1);
    check("t5_first_data", ms_data, 16'h003C);
    drain(3);

    // 6: reset mid-stream with a RAM read in flight
    ms_ready = 1'b1;
    ss_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ss_data = W'(16'h200 + i);
      step();
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    ss_valid = 1'b0;
    check("t6_level", level, 0);
    check("t6_ms_valid", ms_valid, 0);
    check("t6_ae", almost_empty, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_stale", ms_valid, 0);
    end
    ms_ready = 1'b0;
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
